// File: rtl/mem_block_mover_if.sv
// Command/status and memory-port bundle for the block mover.
`timescale 1ns/1ps
interface mem_block_mover_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    // job request, latched by the mover when it accepts start
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] length;
    logic [DW-1:0] fill_value;

    // job status
    logic          busy;
    logic          done;
    logic [AW-1:0] words_done;

    // single-port data memory (combinational read, write on posedge)
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // mover side
    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_value, mem_rdata,
        output busy, done, words_done, mem_addr, mem_write, mem_wdata
    );

    // requester / memory side
    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_value, mem_rdata,
        input  busy, done, words_done, mem_addr, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: bus initiator that copies a block of memory words (COPY) or
// fills a block with a constant (FILL). Every output comes straight from a
// register, so mem_write never depends combinationally on start.
`timescale 1ns/1ps
module mem_block_mover #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_block_mover_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FL   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;

    // job bookkeeping
    logic [AW-1:0] src_ptr_q;
    logic [AW-1:0] dst_ptr_q;
    logic [AW-1:0] remain_q;
    logic [AW-1:0] words_done_q;

    // registered outputs; mem_wdata_q doubles as the COPY data register
    logic          busy_q;
    logic          done_q;
    logic          mem_write_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    // post-beat values; pointers wrap modulo 2^AW
    logic [AW-1:0] src_ptr_d;
    logic [AW-1:0] dst_ptr_d;
    logic [AW-1:0] remain_d;
    logic [AW-1:0] words_done_d;
    logic          last_word_c;

    // Next pointer/count values shared by the WR and FL beats.
    always_comb begin
        src_ptr_d    = src_ptr_q + AW'(1);
        dst_ptr_d    = dst_ptr_q + AW'(1);
        remain_d     = remain_q - AW'(1);
        words_done_d = words_done_q + AW'(1);
        last_word_c  = (remain_q == AW'(1));
    end

    // Job sequencer: state plus the outputs belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remain_q     <= '0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // no queuing: a request is only seen here
                    if (bus.start) begin
                        src_ptr_q    <= bus.src_addr;
                        dst_ptr_q    <= bus.dst_addr;
                        remain_q     <= bus.length;
                        words_done_q <= '0;
                        busy_q       <= 1'b1;
                        if (bus.length == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            mem_write_q <= 1'b0;
                        end else if (!bus.mode) begin
                            state_q     <= S_RD;
                            mem_addr_q  <= bus.src_addr;
                            mem_write_q <= 1'b0;
                        end else begin
                            state_q     <= S_FL;
                            mem_addr_q  <= bus.dst_addr;
                            mem_wdata_q <= bus.fill_value;
                            mem_write_q <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    // capture the source word and present it at the destination
                    state_q     <= S_WR;
                    mem_addr_q  <= dst_ptr_q;
                    mem_wdata_q <= bus.mem_rdata;
                    mem_write_q <= 1'b1;
                end

                S_WR: begin
                    src_ptr_q    <= src_ptr_d;
                    dst_ptr_q    <= dst_ptr_d;
                    remain_q     <= remain_d;
                    words_done_q <= words_done_d;
                    mem_write_q  <= 1'b0;
                    if (last_word_c) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_RD;
                        mem_addr_q <= src_ptr_d;
                    end
                end

                S_FL: begin
                    // fill value stays parked in mem_wdata_q for the whole run
                    dst_ptr_q    <= dst_ptr_d;
                    remain_q     <= remain_d;
                    words_done_q <= words_done_d;
                    if (last_word_c) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        mem_write_q <= 1'b0;
                    end else begin
                        state_q     <= S_FL;
                        mem_addr_q  <= dst_ptr_d;
                        mem_write_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mem_write_q <= 1'b0;
                end

                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Output drive.
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.words_done = words_done_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural memory, reference memory image and a
// scoreboard of expected writes (address, data, cycle).
`timescale 1ns/1ps
module tb_mem_block_mover;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [DW-1:0] WA = 32'h0A0A_0A0A;
    localparam logic [DW-1:0] WB = 32'h0B0B_0B0B;
    localparam logic [DW-1:0] WC = 32'h0C0C_0C0C;
    localparam logic [DW-1:0] WD = 32'h0D0D_0D0D;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    mem_block_mover_if #(.AW(AW), .DW(DW)) bus ();

    mem_block_mover #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned busy_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned wr_cnt   = 0;
    int unsigned extra_wr = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [DW-1:0] pat(input int unsigned i);
        return 32'hC0DE_0000 ^ 32'(i * 32'h9E37);
    endfunction

    // Monitor: busy/done accounting and scoreboard comparison of every write.
    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            check("done_while_busy", 64'(bus.busy), 64'd1);
        end
        if (bus.mem_write) begin
            wr_cnt++;
            check("write_while_busy", 64'(bus.busy), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(bus.mem_wdata), 64'(mon_e.data));
                check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
            end else begin
                extra_wr++;
            end
        end
    end

    // Expected COPY writes: forward, one word at a time, so overlap propagates.
    task automatic plan_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input int unsigned nwr, input int unsigned e0);
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        wr_t           w;
        for (int k = 0; k < int'(nwr); k++) begin
            s = src + AW'(k);
            d = dst + AW'(k);
            ref_mem[d] = ref_mem[s];
            w.addr = d;
            w.data = ref_mem[d];
            w.cyc  = 32'(e0 + 2 * k + 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic plan_fill(input logic [AW-1:0] dst, input int unsigned n,
                             input logic [DW-1:0] val, input int unsigned e0);
        logic [AW-1:0] d;
        wr_t           w;
        for (int k = 0; k < int'(n); k++) begin
            d = dst + AW'(k);
            ref_mem[d] = val;
            w.addr = d;
            w.data = val;
            w.cyc  = 32'(e0 + k);
            exp_q.push_back(w);
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        extra_wr = 0;
    endtask

    task automatic drive(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] f);
        bus.mode       = m;
        bus.src_addr   = s;
        bus.dst_addr   = d;
        bus.length     = l;
        bus.fill_value = f;
        bus.start      = 1'b1;
    endtask

    task automatic wait_idle(input int unsigned budget, input string tag);
        int unsigned n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check({tag, "_timeout"}, 64'(bus.busy), 64'd0);
    endtask

    // One complete job launched from IDLE at a negedge; checks its totals.
    task automatic run_job(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] l, input logic [DW-1:0] f, input string tag);
        int unsigned e0;
        int unsigned exp_busy;
        e0 = cyc + 1;
        if (l == '0)   exp_busy = 1;
        else if (m)    exp_busy = int'(l) + 1;
        else           exp_busy = 2 * int'(l) + 1;
        if (m) plan_fill(d, int'(l), f, e0);
        else   plan_copy(s, d, int'(l), e0);
        clear_counts();
        drive(m, s, d, l, f);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(exp_busy + 4, tag);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_words_done"}, 64'(bus.words_done), 64'(l));
        check({tag, "_write_count"}, 64'(wr_cnt), 64'(l));
        check({tag, "_extra_writes"}, 64'(extra_wr), 64'd0);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v;
        int unsigned   e0;
        logic [AW-1:0] rs;
        logic [AW-1:0] rl;

        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD;
        ref_mem[0] = WA; ref_mem[1] = WB; ref_mem[2] = WC; ref_mem[3] = WD;

        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_words_done", 64'(bus.words_done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // COPY 4 words
        run_job(1'b0, 16'h0000, 16'h0010, 16'd4, '0, "copy4");
        check("copy4_m16", 64'(mem[16]), 64'(WA));
        check("copy4_m17", 64'(mem[17]), 64'(WB));
        check("copy4_m18", 64'(mem[18]), 64'(WC));
        check("copy4_m19", 64'(mem[19]), 64'(WD));
        repeat (3) @(negedge clk);
        check("copy4_words_done_hold", 64'(bus.words_done), 64'd4);

        // FILL 3 words
        run_job(1'b1, '0, 16'h0008, 16'd3, 32'hDEAD_BEEF, "fill3");
        for (int i = 8; i <= 10; i++) check("fill3_mem", 64'(mem[i]), 64'h0000_0000_DEAD_BEEF);
        check("fill3_m11_untouched", 64'(mem[11]), 64'(pat(11)));

        // zero length
        run_job(1'b0, 16'h0100, 16'h0200, 16'd0, '0, "len0");
        check("len0_dst_untouched", 64'(mem[16'h0200]), 64'(pat(16'h0200)));

        // start held high through the job: one job, then a fresh one from IDLE
        v  = 32'h5555_AAAA;
        e0 = cyc + 1;
        plan_fill(16'h0020, 2, v, e0);
        plan_fill(16'h0020, 2, v, e0 + 4);
        clear_counts();
        drive(1'b1, '0, 16'h0020, 16'd2, v);
        @(posedge clk);
        @(negedge clk);
        wait_idle(10, "hold1");
        check("hold_first_busy", 64'(busy_cnt), 64'd3);
        check("hold_first_done", 64'(done_cnt), 64'd1);
        @(negedge clk);
        check("hold_restart", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_idle(10, "hold2");
        check("hold_total_busy", 64'(busy_cnt), 64'd6);
        check("hold_total_done", 64'(done_cnt), 64'd2);
        check("hold_writes", 64'(wr_cnt), 64'd4);
        check("hold_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("hold_stays_idle", 64'(bus.busy), 64'd0);

        // reset after the 2nd write of a 5-word COPY
        e0 = cyc + 1;
        plan_copy(16'h0040, 16'h0080, 2, e0);
        clear_counts();
        drive(1'b0, 16'h0040, 16'h0080, 16'd5, '0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_mem_write", 64'(bus.mem_write), 64'd0);
        check("abort_words_done", 64'(bus.words_done), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_writes", 64'(wr_cnt), 64'd2);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_pending", 64'(exp_q.size()), 64'd0);
        check("abort_m81", 64'(mem[16'h0081]), 64'(pat(16'h0041)));
        check("abort_m82_untouched", 64'(mem[16'h0082]), 64'(pat(16'h0082)));

        // overlapping forward copy replicates mem[0]
        run_job(1'b0, 16'h0000, 16'h0001, 16'd3, '0, "overlap");
        for (int i = 1; i <= 3; i++) check("overlap_mem", 64'(mem[i]), 64'(WA));

        // address wrap during FILL
        run_job(1'b1, '0, 16'hFFFE, 16'd3, 32'h7777_0001, "wrap");
        check("wrap_mFFFE", 64'(mem[16'hFFFE]), 64'h7777_0001);
        check("wrap_mFFFF", 64'(mem[16'hFFFF]), 64'h7777_0001);
        check("wrap_m0000", 64'(mem[0]), 64'h7777_0001);
        check("wrap_m0001_untouched", 64'(mem[1]), 64'(WA));

        // a few random non-overlapping copies
        for (int r = 0; r < 3; r++) begin
            rs = AW'($urandom_range(16'h0300, 16'h03F0));
            rl = AW'($urandom_range(1, 6));
            run_job(1'b0, rs, AW'(16'h0500 + r * 16'h20), rl, '0, "rand_copy");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
